key_scan_scheduler: RTL and testbench
=====================================

KEY_SCAN_SCHEDULER -- requirements
Module: key_scan_scheduler

Interface
REQ-001 SHALL have parameter N_KEYS, default 8, number of key inputs (2..64).
REQ-002 SHALL have parameter TICK_DIV, default 4, clk cycles per scan tick (>=1).
REQ-003 SHALL have parameter DEB_COUNT, default 4, consecutive differing visits needed to accept a change (1..15).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  system clock; all flops rise on posedge clk.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port keys  input  N_KEYS  raw key levels, 1 = pressed.
REQ-008 SHALL have port evt_valid  output  1  event available.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-010 SHALL have port evt_key  output  $clog2(N_KEYS)  index of key in head event.
REQ-011 SHALL have port evt_on  output  1  1 = press, 0 = release.
REQ-012 SHALL have port key_state  output  N_KEYS  current debounced level per key.
REQ-013 SHALL have port overflow  output  1  sticky, set when an event is dropped.

Function
REQ-014 SHALL run a prescaler counting 0..TICK_DIV-1; a tick is asserted when it reaches TICK_DIV-1.
REQ-015 SHALL keep a scan index 0..N_KEYS-1, advanced by 1 per tick, wrapping from N_KEYS-1 to 0.
REQ-016 SHALL keep one 4-bit counter per key in a register array, updated through one shared comparator/incrementer; only the indexed key is touched per tick.
REQ-017 On a tick: if keys[idx] equals key_state[idx], cnt[idx] SHALL clear to 0.
REQ-018 On a tick: if they differ and cnt[idx] == DEB_COUNT-1, key_state[idx] SHALL take keys[idx], cnt[idx] SHALL clear, and event {idx, keys[idx]} SHALL be pushed.
REQ-019 On a tick: if they differ otherwise, cnt[idx] SHALL increment by 1.
REQ-020 A push SHALL land in the FIFO on the same edge that updates key_state; evt_valid SHALL rise the following cycle.
REQ-021 evt_valid SHALL equal FIFO not-empty; evt_key/evt_on SHALL show the head entry and stay stable while evt_valid && !evt_ready.
REQ-022 Pop SHALL occur on evt_valid && evt_ready.
REQ-023 When full, a push with a simultaneous pop SHALL be accepted with no drop.
REQ-024 When full, a push without a pop SHALL drop the event and set overflow; key_state SHALL still update.
REQ-025 overflow SHALL clear only on reset.
REQ-026 Read and write pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide, with full/empty from MSB compare.

Reset
REQ-027 During rst: prescaler, scan index, all cnt, key_state, FIFO pointers and overflow SHALL be 0; evt_valid SHALL be 0.
REQ-028 Reset asserted mid-debounce or with a non-empty FIFO SHALL discard all state; no stale event SHALL appear after release.
REQ-029 The first tick after release SHALL occur TICK_DIV cycles after the first active edge.

Configuration
REQ-030 With KEY_SCAN_SYNC_EN defined: keys SHALL pass through a 2-flop synchronizer (reset 0), adding 2 cycles of input latency.
REQ-031 Without KEY_SCAN_SYNC_EN: keys SHALL be sampled directly, with inputs assumed synchronous to clk.

Structure
REQ-032 A shared package key_scan_pkg SHALL hold the event struct (key index, on flag) and the counter width constant CNT_W=4.
REQ-033 The FIFO SHALL be the sub-module key_evt_fifo, parameterised by FIFO_DEPTH and entry width.

Verification (N_KEYS=8, TICK_DIV=4, DEB_COUNT=4, FIFO_DEPTH=4, evt_ready=1 unless stated)
REQ-034 keys[3] 0->1 held -> exactly one event key=3 on=1 within 4*32+2 cycles, and key_state[3]=1.
REQ-035 keys[5] toggled for 3 visits then restored -> no event, key_state[5]=0, cnt[5] back to 0.
REQ-036 evt_ready=0, 5 keys pressed in turn -> 4 events held in order, overflow=1, key_state=all five set; raising evt_ready drains exactly 4 events.
REQ-037 FIFO full with evt_ready=1 pulsed on the push cycle -> push accepted, overflow stays 0.
REQ-038 rst pulsed while 2 events queued and keys[1] mid-debounce -> evt_valid=0 and key_state=0 after reset; re-detect of key 1 needs a full 4 visits.
REQ-039 keys[7] released after press -> event key=7 on=0; the index wraps 7->0 without skipping key 0.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types and constants for the key scan scheduler.
package key_scan_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned KEY_W = 6;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             on;
    } key_evt_t;

    localparam int unsigned EVT_W = $bits(key_evt_t);

endpackage

// File: rtl/key_evt_fifo.sv
// Event FIFO with extra-MSB pointers; a push into a full FIFO is accepted
// only when a pop happens on the same edge, otherwise it is reported as dropped.
module key_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        drop_o   = push_i && full_o && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/key_scan_scheduler.sv
// Time-multiplexed key debouncer: one key per scan tick, changes queued as events.
// Optional KEY_SCAN_SYNC_EN adds a 2-flop input synchronizer.
module key_scan_scheduler
    import key_scan_pkg::*;
#(
    parameter int unsigned N_KEYS     = 8,
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned DEB_COUNT  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_KEYS-1:0]         keys,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_KEYS)-1:0] evt_key,
    output logic                      evt_on,
    output logic [N_KEYS-1:0]         key_state,
    output logic                      overflow
);

    localparam int unsigned IW = $clog2(N_KEYS);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [N_KEYS-1:0] keys_s;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];
    logic [N_KEYS-1:0] key_state_q, key_state_d;
    logic              overflow_q, overflow_d;
    logic              tick, sample, push, empty, full, drop;
    key_evt_t          push_evt, head_evt;

`ifdef KEY_SCAN_SYNC_EN
    logic [N_KEYS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
        end
    end

    assign keys_s = sync2_q;
`else
    assign keys_s = keys;
`endif

    // Prescaler and scan index.
    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) idx_d = (idx_q == IW'(N_KEYS - 1)) ? '0 : idx_q + IW'(1);
    end

    // Shared debounce compare/increment for the indexed key only.
    always_comb begin
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        push        = 1'b0;
        sample      = keys_s[idx_q];
        if (tick) begin
            if (sample == key_state_q[idx_q]) begin
                cnt_d[idx_q] = '0;
            end else if (cnt_q[idx_q] == CNT_W'(DEB_COUNT - 1)) begin
                key_state_d[idx_q] = sample;
                cnt_d[idx_q]       = '0;
                push               = 1'b1;
            end else begin
                cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
            end
        end
        push_evt.key = KEY_W'(idx_q);
        push_evt.on  = sample;
        overflow_d   = overflow_q | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            key_state_q <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < int'(N_KEYS); i++) cnt_q[i] <= '0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            key_state_q <= key_state_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_evt),
        .pop_i   (evt_ready),
        .data_o  (head_evt),
        .empty_o (empty),
        .full_o  (full),
        .drop_o  (drop)
    );

    assign evt_valid = !empty;
    assign evt_key   = head_evt.key[IW-1:0];
    assign evt_on    = head_evt.on;
    assign key_state = key_state_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_scan_scheduler.sv
// Bench for key_scan_scheduler: directed scenarios plus random key activity,
// every cycle compared against a tick-arithmetic reference model.
module tb_key_scan_scheduler;

    localparam int N     = 8;
    localparam int TD    = 4;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] kb  = '0;
    logic         rdy = 1'b1;
    logic         evt_valid, evt_on, overflow;
    logic [2:0]   evt_key;
    logic [N-1:0] key_state;

    int total = 0;
    int bad   = 0;

    // Reference model: edges since reset, per-key level/count, event queue.
    int m_cyc;
    bit m_state [N];
    int m_cnt   [N];
    int m_q[$];
    int pop_log[$];
    bit m_ovf;

    key_scan_scheduler #(
        .N_KEYS(N), .TICK_DIV(TD), .DEB_COUNT(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .keys(kb), .evt_valid(evt_valid),
        .evt_ready(rdy), .evt_key(evt_key), .evt_on(evt_on),
        .key_state(key_state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit will_push();
        int n, k;
        n = m_cyc + 1;
        if (n % TD != 0) return 1'b0;
        k = (n / TD - 1) % N;
        return (kb[k] != m_state[k]) && (m_cnt[k] == DEB - 1);
    endfunction

    function automatic bit next_visits(input int k);
        int n;
        n = m_cyc + 1;
        return (n % TD == 0) && (((n / TD - 1) % N) == k);
    endfunction

    task automatic model_edge();
        bit pop, evt;
        int k, ev;
        if (rst) begin
            m_cyc = 0;
            m_ovf = 1'b0;
            m_q.delete();
            for (int i = 0; i < N; i++) begin
                m_state[i] = 1'b0;
                m_cnt[i]   = 0;
            end
            return;
        end
        pop = rdy && (m_q.size() > 0);
        evt = 1'b0;
        ev  = 0;
        m_cyc++;
        if (m_cyc % TD == 0) begin
            k = (m_cyc / TD - 1) % N;
            if (kb[k] == m_state[k]) m_cnt[k] = 0;
            else if (m_cnt[k] == DEB - 1) begin
                m_state[k] = kb[k];
                m_cnt[k]   = 0;
                evt        = 1'b1;
                ev         = k * 2 + int'(kb[k]);
            end else m_cnt[k]++;
        end
        if (pop) begin
            pop_log.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (evt) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] ms;
        for (int i = 0; i < N; i++) ms[i] = m_state[i];
        chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("evt_key", 32'(evt_key), 32'(m_q[0] / 2));
            chk("evt_on",  32'(evt_on),  32'(m_q[0] % 2));
        end
        chk("key_state", 32'(key_state), 32'(ms));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        pop_log.delete();
    endtask

    task automatic wait_visit(input int k);
        int guard = 0;
        while (!next_visits(k) && guard < 64) begin
            cycle();
            guard++;
        end
        chk("visit_bound", 32'(guard < 64), 32'd1);
    endtask

    task automatic wait_state(input int k, input bit lvl, input int budget);
        int guard = 0;
        while (key_state[k] !== lvl && guard < budget) begin
            cycle();
            guard++;
        end
        chk("state_bound", 32'(guard < budget), 32'd1);
    endtask

    initial begin
        int guard;
        #1;
        do_reset();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_state", 32'(key_state), 32'd0);

        // Single press on key 3 right after reset.
        kb[3] = 1'b1;
        repeat (4 * 32 + 2) cycle();
        chk("r34_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) chk("r34_evt", 32'(pop_log[0]), 32'(3 * 2 + 1));
        chk("r34_state", 32'(key_state[3]), 32'd1);

        // Three-visit glitch on key 5 must not be accepted.
        pop_log.delete();
        kb[5] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            wait_visit(5);
            cycle();
        end
        kb[5] = 1'b0;
        wait_visit(5);
        cycle();
        chk("r35_events", 32'(pop_log.size()), 32'd0);
        chk("r35_state", 32'(key_state[5]), 32'd0);
        chk("r35_cnt", 32'(dut.cnt_q[5]), 32'd0);

        // Overflow: five presses with the consumer stalled.
        rdy = 1'b0;
        kb  = kb | 8'b0101_0111;
        guard = 0;
        while (key_state !== 8'h5F && guard < 400) begin
            cycle();
            guard++;
        end
        chk("r36_bound", 32'(guard < 400), 32'd1);
        chk("r36_ovf", 32'(overflow), 32'd1);
        chk("r36_state", 32'(key_state), 32'h5F);
        pop_log.delete();
        rdy = 1'b1;
        repeat (10) cycle();
        chk("r36_drain", 32'(pop_log.size()), 32'd4);

        // Full FIFO with a pop on the push edge: no drop.
        kb = '0;
        do_reset();
        rdy = 1'b0;
        kb  = 8'h1F;
        guard = 0;
        while (!(m_q.size() == DEPTH && will_push()) && guard < 400) begin
            cycle();
            guard++;
        end
        chk("r37_bound", 32'(guard < 400), 32'd1);
        rdy = 1'b1;
        cycle();
        rdy = 1'b0;
        chk("r37_ovf", 32'(overflow), 32'd0);
        chk("r37_valid", 32'(evt_valid), 32'd1);
        rdy = 1'b1;
        repeat (10) cycle();
        chk("r37_total", 32'(pop_log.size()), 32'd5);

        // Reset with queued events and key 1 mid-debounce.
        kb = '0;
        do_reset();
        rdy = 1'b0;
        kb  = 8'b0000_0101;
        guard = 0;
        while (m_q.size() < 2 && guard < 300) begin
            cycle();
            guard++;
        end
        chk("r38_bound", 32'(guard < 300), 32'd1);
        kb[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            wait_visit(1);
            cycle();
        end
        kb = 8'b0000_0010;
        do_reset();
        chk("r38_valid", 32'(evt_valid), 32'd0);
        chk("r38_state", 32'(key_state), 32'd0);
        for (int v = 1; v <= 4; v++) begin
            wait_visit(1);
            cycle();
            chk("r38_redetect", 32'(key_state[1]), 32'(v == 4));
        end

        // Release event on key 7 and index wrap 7 -> 0 -> 1.
        rdy = 1'b1;
        kb  = '0;
        do_reset();
        kb[7] = 1'b1;
        wait_state(7, 1'b1, 300);
        repeat (3) cycle();
        pop_log.delete();
        kb[7] = 1'b0;
        wait_state(7, 1'b0, 300);
        repeat (3) cycle();
        chk("r39_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) chk("r39_evt", 32'(pop_log[0]), 32'(7 * 2));
        wait_visit(7);
        cycle();
        chk("r39_wrap0", 32'(dut.idx_q), 32'd0);
        repeat (TD) cycle();
        chk("r39_wrap1", 32'(dut.idx_q), 32'd1);

        // Random key activity and consumer stalls.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 24) == 0) kb[$urandom_range(0, N - 1)] ^= 1'b1;
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
